decode_stage: RTL

Registered RV32/RV64 instruction decode stage sitting between fetch and execute. Accepts raw 32-bit instruction words with their PC over a valid/ready handshake and classifies them by opcode into instruction type and immediate format. Produces an XLEN-wide sign-extended immediate, register indices, funct fields and an illegal-instruction flag. A two-entry skid buffer keeps full throughput under downstream back-pressure, and a flush input discards in-flight entries.

---
 rtl/riscv_pkg.sv | 90 +++++++++
 rtl/decode_stage_if.sv | 49 ++++
 rtl/decode_stage_imm_gen.sv | 44 ++++
 rtl/decode_stage.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared RISC-V definitions used by the decode stage:
//   opcode_e           - major opcodes (instr[6:0], including the 2'b11 suffix)
//   instruction_type_e - instruction format class delivered to execute
//   imm_type_e         - immediate format selector for imm_gen
//   occ_e              - decode-stage buffer occupancy (FSM state)
//   decoded_instr_t    - one fully decoded buffer entry. pc/imm are held at
//                        the widest supported XLEN (64) and truncated at the
//                        output ports when the stage is built for RV32.
// ---------------------------------------------------------------------------
package riscv_pkg;

   localparam int XLEN_MAX = 64;

   typedef enum logic [6:0] {
      LOAD      = 7'b0000011,
      MISC_MEM  = 7'b0001111,
      OP_IMM    = 7'b0010011,
      AUIPC     = 7'b0010111,
      OP_IMM_32 = 7'b0011011,
      STORE     = 7'b0100011,
      OP        = 7'b0110011,
      LUI       = 7'b0110111,
      OP_32     = 7'b0111011,
      BRANCH    = 7'b1100011,
      JALR      = 7'b1100111,
      JAL       = 7'b1101111,
      SYSTEM    = 7'b1110011
   } opcode_e;

   typedef enum logic [2:0] {
      R_TYPE       = 3'd0,
      I_TYPE       = 3'd1,
      S_TYPE       = 3'd2,
      B_TYPE       = 3'd3,
      U_TYPE       = 3'd4,
      J_TYPE       = 3'd5,
      UNKNOWN_TYPE = 3'd7
   } instruction_type_e;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5
   } imm_type_e;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_e;

   localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
   localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   typedef struct packed {
      logic [XLEN_MAX-1:0] pc;
      instruction_type_e   itype;
      imm_type_e           imm_type;
      logic [XLEN_MAX-1:0] imm;
      logic [4:0]          rd;
      logic [4:0]          rs1;
      logic [4:0]          rs2;
      logic [2:0]          funct3;
      logic [6:0]          funct7;
      logic                illegal;
      logic                is_muldiv;
   } decoded_instr_t;

   // Value of an empty entry: all fields zero, type UNKNOWN.
   localparam decoded_instr_t DECODED_RESET = '{
      pc:        '0,
      itype:     UNKNOWN_TYPE,
      imm_type:  IMM_NONE,
      imm:       '0,
      rd:        '0,
      rs1:       '0,
      rs2:       '0,
      funct3:    '0,
      funct7:    '0,
      illegal:   1'b0,
      is_muldiv: 1'b0
   };

endpackage

// File: rtl/decode_stage_if.sv
// ---------------------------------------------------------------------------
// decode_stage_if
// Upstream (fetch -> decode) and downstream (decode -> execute) handshake
// bundle of the decode stage.
//   in_valid/in_ready/in_instr/in_pc   : word from fetch
//   out_valid/out_ready/out_*          : decoded entry to execute
// Modports:
//   master - the pipeline neighbour side (drives in_*, out_ready)
//   slave  - the decode stage itself
// Handshake: a transfer happens on a rising clk edge where valid && ready
// are both 1. While valid is high and ready low the sender holds its
// payload stable; valid never depends on ready.
// ---------------------------------------------------------------------------
interface decode_stage_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [XLEN-1:0] in_pc;

   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [2:0]      out_itype;
   logic [2:0]      out_imm_type;
   logic [XLEN-1:0] out_imm;
   logic [4:0]      out_rd;
   logic [4:0]      out_rs1;
   logic [4:0]      out_rs2;
   logic [2:0]      out_funct3;
   logic [6:0]      out_funct7;
   logic            out_illegal;
   logic            out_is_muldiv;

   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_pc, out_itype, out_imm_type, out_imm,
             out_rd, out_rs1, out_rs2, out_funct3, out_funct7, out_illegal,
             out_is_muldiv
   );

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_pc, out_itype, out_imm_type, out_imm,
             out_rd, out_rs1, out_rs2, out_funct3, out_funct7, out_illegal,
             out_is_muldiv
   );
endinterface

// File: rtl/decode_stage_imm_gen.sv
// ---------------------------------------------------------------------------
// imm_gen
// Combinational RISC-V immediate builder. Assembles the I/S/B/U/J immediate
// from the instruction word and sign-extends it from instr[31] to XLEN.
// IMM_NONE yields zero.
// Ports:
//   i_instr    [31:0]     raw instruction word
//   i_imm_type imm_type_e immediate format
//   o_imm      [XLEN-1:0] sign-extended immediate
// ---------------------------------------------------------------------------
module imm_gen
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     i_instr,
   input  imm_type_e       i_imm_type,
   output logic [XLEN-1:0] o_imm
);

   logic [31:0] w_imm32;
   logic        w_unused_opcode;

   always_comb begin
      w_imm32 = '0;
      case (i_imm_type)
         IMM_I: w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
         IMM_S: w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
         IMM_B: w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                           i_instr[30:25], i_instr[11:8], 1'b0};
         IMM_U: w_imm32 = {i_instr[31:12], 12'b0};
         IMM_J: w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                           i_instr[20], i_instr[30:21], 1'b0};
         default: w_imm32 = '0;
      endcase
   end

   // Signed size cast: sign-extends to 64 bits on RV64, identity on RV32.
   assign o_imm = XLEN'($signed(w_imm32));

   // The opcode bits never carry immediate data.
   assign w_unused_opcode = ^i_instr[6:0];

endmodule

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
// Registered RV32/RV64 decode stage between fetch and execute. Each accepted
// word is decoded combinationally and stored fully decoded in a two-entry
// skid buffer (head + skid), so the stage sustains one word per cycle and
// absorbs one extra word when execute stalls.
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset; drops all entries at once
//   flush       discard all entries on the next edge; same-cycle input ignored
//   bus         decode_stage_if.slave (in_* from fetch, out_* to execute)
//   o_dbg_count occupancy FSM state (occ_e)
// Parameter: XLEN = 32 or 64 (width of pc and immediate).
// Build option: define RV_M_EXT_EN to accept M-extension OP/OP_32 encodings
// (funct7=0000001) and flag them on out_is_muldiv; without it those
// encodings are illegal and out_is_muldiv stays 0.
// ---------------------------------------------------------------------------
module decode_stage
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   decode_stage_if.slave bus,
   output logic [1:0]    o_dbg_count
);

   localparam bit RV64 = (XLEN == 64);

   occ_e              r_count;
   occ_e              w_count_nxt;
   logic              r_in_ready;
   decoded_instr_t    r_head;
   decoded_instr_t    r_skid;

   logic              w_in_fire;
   logic              w_out_fire;
   logic              w_out_valid;
   opcode_e           w_opcode;
   logic [6:0]        w_funct7;
   instruction_type_e w_itype;
   imm_type_e         w_imm_type;
   logic              w_illegal;
   logic              w_muldiv;
   logic [XLEN-1:0]   w_imm;
   decoded_instr_t    w_dec;
   logic              w_unused_hi;

   // ---------------------------------------------------------------- decode
   assign w_opcode = opcode_e'(bus.in_instr[6:0]);
   assign w_funct7 = bus.in_instr[31:25];

   always_comb begin
      w_itype    = UNKNOWN_TYPE;
      w_imm_type = IMM_NONE;
      w_illegal  = 1'b0;
      w_muldiv   = 1'b0;
      case (w_opcode)
         OP, OP_32: begin
            if ((w_opcode == OP_32) && !RV64) begin
               w_illegal = 1'b1;
            end else if ((w_funct7 == FUNCT7_BASE) || (w_funct7 == FUNCT7_ALT)) begin
               w_itype = R_TYPE;
`ifdef RV_M_EXT_EN
            end else if (w_funct7 == FUNCT7_MULDIV) begin
               w_itype  = R_TYPE;
               w_muldiv = 1'b1;
`endif
            end else begin
               w_illegal = 1'b1;
            end
         end
         LOAD, OP_IMM, JALR, MISC_MEM, SYSTEM: begin
            w_itype    = I_TYPE;
            w_imm_type = IMM_I;
         end
         OP_IMM_32: begin
            if (RV64) begin
               w_itype    = I_TYPE;
               w_imm_type = IMM_I;
            end else begin
               w_illegal = 1'b1;
            end
         end
         STORE: begin
            w_itype    = S_TYPE;
            w_imm_type = IMM_S;
         end
         BRANCH: begin
            w_itype    = B_TYPE;
            w_imm_type = IMM_B;
         end
         LUI, AUIPC: begin
            w_itype    = U_TYPE;
            w_imm_type = IMM_U;
         end
         JAL: begin
            w_itype    = J_TYPE;
            w_imm_type = IMM_J;
         end
         // Covers unknown opcodes and every word with instr[1:0] != 2'b11.
         default: w_illegal = 1'b1;
      endcase
      // Illegal words travel on, but with no type/immediate information.
      if (w_illegal) begin
         w_itype    = UNKNOWN_TYPE;
         w_imm_type = IMM_NONE;
         w_muldiv   = 1'b0;
      end
   end

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .i_instr    (bus.in_instr),
      .i_imm_type (w_imm_type),
      .o_imm      (w_imm)
   );

   always_comb begin
      w_dec           = DECODED_RESET;
      w_dec.pc        = 64'(bus.in_pc);
      w_dec.itype     = w_itype;
      w_dec.imm_type  = w_imm_type;
      w_dec.imm       = 64'(w_imm);
      w_dec.rd        = bus.in_instr[11:7];
      w_dec.rs1       = bus.in_instr[19:15];
      w_dec.rs2       = bus.in_instr[24:20];
      w_dec.funct3    = bus.in_instr[14:12];
      w_dec.funct7    = w_funct7;
      w_dec.illegal   = w_illegal;
      w_dec.is_muldiv = w_muldiv;
   end

   // ------------------------------------------------------ occupancy FSM
   assign w_out_valid = (r_count != EMPTY);
   // A flushed cycle never counts as an input transfer.
   assign w_in_fire   = bus.in_valid && r_in_ready && !flush;
   assign w_out_fire  = w_out_valid && bus.out_ready;

   always_comb begin
      w_count_nxt = r_count;
      if (flush) begin
         w_count_nxt = EMPTY;
      end else begin
         case (r_count)
            EMPTY: if (w_in_fire) w_count_nxt = ONE;
            ONE: begin
               if (w_in_fire && !w_out_fire)      w_count_nxt = TWO;
               else if (!w_in_fire && w_out_fire) w_count_nxt = EMPTY;
            end
            // in_ready is low in TWO, so only a drain can happen here.
            TWO:     if (w_out_fire) w_count_nxt = ONE;
            default: w_count_nxt = EMPTY;
         endcase
      end
   end

   // in_ready is registered from the next occupancy so it never depends on
   // the current cycle's inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count    <= EMPTY;
         r_in_ready <= 1'b1;
      end else begin
         r_count    <= w_count_nxt;
         r_in_ready <= (w_count_nxt != TWO);
      end
   end

   // ------------------------------------------------------------ datapath
   // Head loads the new word when it is (or is about to become) the oldest
   // entry; otherwise the word parks in skid until head drains.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head <= DECODED_RESET;
         r_skid <= DECODED_RESET;
      end else if (!flush) begin
         if (w_in_fire && ((r_count == EMPTY) || ((r_count == ONE) && w_out_fire))) begin
            r_head <= w_dec;
         end else if (w_out_fire && (r_count == TWO)) begin
            r_head <= r_skid;
         end
         if (w_in_fire && (r_count == ONE) && !w_out_fire) begin
            r_skid <= w_dec;
         end
      end
   end

   // -------------------------------------------------------------- outputs
   assign bus.in_ready      = r_in_ready;
   assign bus.out_valid     = w_out_valid;
   assign bus.out_pc        = r_head.pc[XLEN-1:0];
   assign bus.out_itype     = r_head.itype;
   assign bus.out_imm_type  = r_head.imm_type;
   assign bus.out_imm       = r_head.imm[XLEN-1:0];
   assign bus.out_rd        = r_head.rd;
   assign bus.out_rs1       = r_head.rs1;
   assign bus.out_rs2       = r_head.rs2;
   assign bus.out_funct3    = r_head.funct3;
   assign bus.out_funct7    = r_head.funct7;
   assign bus.out_illegal   = r_head.illegal;
   assign bus.out_is_muldiv = r_head.is_muldiv;
   assign o_dbg_count       = r_count;

   // Upper pc/imm bits are unused when built for RV32.
   assign w_unused_hi = ^{r_head.pc, r_head.imm};

endmodule
